// File: rtl/nes_controller_port.sv
// NES joypad emulation: 4021-style parallel-in/serial-out register fed by debounced
// physical buttons or a debugger override word, plus a latch (poll) counter.
module nes_controller_port #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [7:0]             i_pad_buttons_n,
    input  logic                   i_override_en,
    input  logic [7:0]             i_override_buttons,
    input  logic                   i_nes_latch,
    input  logic                   i_nes_clk,
    output logic                   o_nes_data,
    output logic [7:0]             o_buttons_debounced,
    output logic [COUNT_WIDTH-1:0] o_latch_count
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]             sync1_q, sync2_q;
    logic [7:0]             sync_act;
    logic [DB_W-1:0]        db_cnt_q [8];
    logic [DB_W-1:0]        db_cnt_d [8];
    logic [7:0]             deb_q, deb_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   prev_latch_q, prev_clk_q;
    logic [COUNT_WIDTH-1:0] latch_cnt_q, latch_cnt_d;
    logic [7:0]             buttons;

    assign sync_act = ~sync2_q;
    assign buttons  = i_override_en ? i_override_buttons : deb_q;

    // A counter reaching its last value on a still-differing input commits the change.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 8; i++) begin
            db_cnt_d[i] = '0;
            if (sync_act[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync_act[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        shreg_d = shreg_q;
        if (i_nes_latch) begin
            shreg_d = buttons;
        end else if (i_nes_clk && !prev_clk_q) begin
            shreg_d = {1'b1, shreg_q[7:1]};
        end
    end

    always_comb begin
        latch_cnt_d = latch_cnt_q;
        if (!i_nes_latch && prev_latch_q) begin
            latch_cnt_d = latch_cnt_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q      <= 8'hFF;
            sync2_q      <= 8'hFF;
            deb_q        <= 8'h00;
            shreg_q      <= 8'h00;
            prev_latch_q <= 1'b0;
            prev_clk_q   <= 1'b0;
            latch_cnt_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= i_pad_buttons_n;
            sync2_q      <= sync1_q;
            deb_q        <= deb_d;
            shreg_q      <= shreg_d;
            prev_latch_q <= i_nes_latch;
            prev_clk_q   <= i_nes_clk;
            latch_cnt_q  <= latch_cnt_d;
            for (int i = 0; i < 8; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign o_nes_data          = shreg_q[0];
    assign o_buttons_debounced = deb_q;
    assign o_latch_count       = latch_cnt_q;

endmodule

// File: tb/tb_nes_controller_port.sv
// Directed testbench for nes_controller_port (DEBOUNCE_CYCLES=16, COUNT_WIDTH=4).
module tb_nes_controller_port;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pad_n;
    logic       ovr_en;
    logic [7:0] ovr;
    logic       latch;
    logic       nclk;
    logic       data;
    logic [7:0] deb;
    logic [3:0] lcnt;

    int n_checks = 0;
    int n_fail   = 0;

    nes_controller_port #(.DEBOUNCE_CYCLES(16), .COUNT_WIDTH(4)) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_pad_buttons_n    (pad_n),
        .i_override_en      (ovr_en),
        .i_override_buttons (ovr),
        .i_nes_latch        (latch),
        .i_nes_clk          (nclk),
        .o_nes_data         (data),
        .o_buttons_debounced(deb),
        .o_latch_count      (lcnt)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic latch_pulse();
        latch = 1'b1; tick(2);
        latch = 1'b0; tick(1);
    endtask

    task automatic do_reset();
        reset = 1'b1; latch = 1'b0; nclk = 1'b0;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        pad_n = 8'hFF; ovr_en = 1'b0; ovr = 8'h00;
        do_reset();
        n_checks++;
        if (data !== 1'b0) begin n_fail++; $display("FAIL reset_data got %b want 0", data); end
        n_checks++;
        if (deb !== 8'h00) begin n_fail++; $display("FAIL reset_deb got %h want 00", deb); end
        n_checks++;
        if (lcnt !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", lcnt); end
    endtask

    task automatic test_readback();
        logic [10:0] exp_seq;
        exp_seq = {3'b111, 8'b1000_1001};
        ovr_en = 1'b1; ovr = 8'b1000_1001;
        latch_pulse();
        n_checks++;
        if (data !== exp_seq[0]) begin n_fail++; $display("FAIL readback_bit0 got %b want %b", data, exp_seq[0]); end
        for (int k = 1; k <= 10; k++) begin
            nclk = 1'b1; tick(1);
            n_checks++;
            if (data !== exp_seq[k]) begin
                n_fail++; $display("FAIL readback_shift%0d got %b want %b", k, data, exp_seq[k]);
            end
            nclk = 1'b0; tick(2);
        end
        n_checks++;
        if (lcnt !== 4'd1) begin n_fail++; $display("FAIL readback_count got %0d want 1", lcnt); end
    endtask

    task automatic test_debounce();
        logic [3:0] exp_start;
        exp_start = 4'b1000;
        ovr_en = 1'b0;
        pad_n[3] = 1'b0; tick(10);
        pad_n[3] = 1'b1; tick(25);
        n_checks++;
        if (deb !== 8'h00) begin n_fail++; $display("FAIL debounce_glitch got %h want 00", deb); end
        pad_n[3] = 1'b0;
        tick(17);
        n_checks++;
        if (deb !== 8'h00) begin n_fail++; $display("FAIL debounce_early got %h want 00 at 17", deb); end
        tick(1);
        n_checks++;
        if (deb !== 8'h08) begin n_fail++; $display("FAIL debounce_set got %h want 08 at 18", deb); end
        tick(12);
        latch_pulse();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (data !== exp_start[k]) begin
                n_fail++; $display("FAIL debounce_read%0d got %b want %b", k, data, exp_start[k]);
            end
            nclk = 1'b1; tick(1);
            nclk = 1'b0; tick(1);
        end
        pad_n[3] = 1'b1; tick(20);
        n_checks++;
        if (deb !== 8'h00) begin n_fail++; $display("FAIL debounce_release got %h want 00", deb); end
    endtask

    task automatic test_latch_priority();
        ovr_en = 1'b1; ovr = 8'h01;
        latch = 1'b1; nclk = 1'b1; tick(1);
        n_checks++;
        if (data !== 1'b1) begin n_fail++; $display("FAIL prio_load got %b want 1", data); end
        tick(1);
        n_checks++;
        if (data !== 1'b1) begin n_fail++; $display("FAIL prio_noshift got %b want 1", data); end
        ovr = 8'h02; tick(1);
        n_checks++;
        if (data !== 1'b0) begin n_fail++; $display("FAIL prio_track got %b want 0", data); end
        latch = 1'b0; nclk = 1'b0; tick(1);
    endtask

    task automatic test_held_clock();
        ovr_en = 1'b1; ovr = 8'h03;
        latch_pulse();
        n_checks++;
        if (data !== 1'b1) begin n_fail++; $display("FAIL held_load got %b want 1", data); end
        nclk = 1'b1; tick(5);
        n_checks++;
        if (data !== 1'b1) begin n_fail++; $display("FAIL held_once got %b want 1", data); end
        nclk = 1'b0; tick(1);
        nclk = 1'b1; tick(1);
        n_checks++;
        if (data !== 1'b0) begin n_fail++; $display("FAIL held_second got %b want 0", data); end
        nclk = 1'b0; tick(1);
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] pat;
        pat = 8'h5A;
        ovr_en = 1'b1; ovr = 8'hFF;
        latch_pulse();
        for (int k = 0; k < 3; k++) begin
            nclk = 1'b1; tick(1);
            nclk = 1'b0; tick(1);
        end
        do_reset();
        n_checks++;
        if (data !== 1'b0) begin n_fail++; $display("FAIL midreset_data got %b want 0", data); end
        n_checks++;
        if (lcnt !== 4'd0) begin n_fail++; $display("FAIL midreset_count got %0d want 0", lcnt); end
        n_checks++;
        if (deb !== 8'h00) begin n_fail++; $display("FAIL midreset_deb got %h want 00", deb); end
        ovr = pat;
        latch_pulse();
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (data !== pat[k]) begin
                n_fail++; $display("FAIL midreset_bit%0d got %b want %b", k, data, pat[k]);
            end
            nclk = 1'b1; tick(1);
            nclk = 1'b0; tick(1);
        end
        n_checks++;
        if (lcnt !== 4'd1) begin n_fail++; $display("FAIL midreset_recount got %0d want 1", lcnt); end
    endtask

    task automatic test_count_wrap();
        do_reset();
        for (int k = 0; k < 15; k++) latch_pulse();
        n_checks++;
        if (lcnt !== 4'd15) begin n_fail++; $display("FAIL wrap_max got %0d want 15", lcnt); end
        latch_pulse();
        n_checks++;
        if (lcnt !== 4'd0) begin n_fail++; $display("FAIL wrap_zero got %0d want 0", lcnt); end
        latch_pulse();
        n_checks++;
        if (lcnt !== 4'd1) begin n_fail++; $display("FAIL wrap_one got %0d want 1", lcnt); end
    endtask

    initial begin
        reset = 1'b1; pad_n = 8'hFF; ovr_en = 1'b0; ovr = 8'h00;
        latch = 1'b0; nclk = 1'b0;
        tick(2);
        test_reset();
        test_readback();
        test_debounce();
        test_latch_priority();
        test_held_clock();
        test_reset_mid_read();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
